// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
// The bundle struct is sized for the widest supported issue width; narrower builds use the low slots.
package fetch_pkg;

    localparam int          ILEN        = 32;
    localparam int          XLEN        = 64;
    localparam int          MAX_ISSUE_W = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0]             pc;
        logic [MAX_ISSUE_W*ILEN-1:0] instr;
        logic [MAX_ISSUE_W-1:0]      slot_valid;
        logic                        misalign;
    } fetch_bundle_t;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Redirect, decode handshake and preload bus of the fetch front-end.
interface instr_fetch_queue_if #(
    parameter int ISSUE_W   = 2,
    parameter int MEM_BYTES = 65536
);
    localparam int AW = $clog2(MEM_BYTES);

    logic                  redirect_valid;
    logic [63:0]           redirect_pc;
    logic                  out_valid;
    logic                  out_ready;
    logic [63:0]           out_pc;
    logic [32*ISSUE_W-1:0] out_instr;
    logic [ISSUE_W-1:0]    out_slot_valid;
    logic                  out_misalign;
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [7:0]            wr_data;

    modport master (
        output redirect_valid, redirect_pc, out_ready, wr_en, wr_addr, wr_data,
        input  out_valid, out_pc, out_instr, out_slot_valid, out_misalign
    );

    modport slave (
        input  redirect_valid, redirect_pc, out_ready, wr_en, wr_addr, wr_data,
        output out_valid, out_pc, out_instr, out_slot_valid, out_misalign
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous bundle FIFO with flush; the head reads as all-zero while empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_bundle_t            push_data,
    input  logic                     pop,
    output fetch_bundle_t            head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_bundle_t   store [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : store[rd_ptr];

    // NOTE: non-blocking assignments for all registered state, so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage arrays carry no reset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch front-end: byte store, fetch PC, one registered read stage, and a bundle queue to decode.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int          ISSUE_W   = 2,
    parameter int          DEPTH     = 4,
    parameter int          MEM_BYTES = 65536,
    parameter logic [63:0] RESET_PC  = 64'h0
) (
    input logic                clk,
    input logic                rst_n,
    instr_fetch_queue_if.slave bus
);
    localparam int AW = $clog2(MEM_BYTES);
    localparam int NB = 4 * ISSUE_W;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [7:0]          mem      [MEM_BYTES];
    logic [7:0]          rd_bytes [NB];
    logic [63:0]         fpc;
    logic [63:0]         s1_pc;
    logic                s1_valid;
    logic                s1_misalign;
    logic [ISSUE_W-1:0]  s1_slot_valid;
    logic                halt;
    logic [ISSUE_W-1:0]  issue_slot_valid;
    logic                fpc_misaligned;
    logic                issue;
    logic                pop;
    logic [CW:0]         occupancy;
    logic [CW-1:0]       q_count;
    logic                q_full;
    logic                q_empty;
    fetch_bundle_t       s1_bundle;
    fetch_bundle_t       head;
    logic                unused_full;

    assign fpc_misaligned = (fpc[1:0] != 2'b00);
    assign pop            = !q_empty && bus.out_ready;
    assign occupancy      = {1'b0, q_count} + (CW+1)'(s1_valid);
    // A full pipeline may still issue when the head leaves in the same cycle.
    assign issue = !halt && !bus.redirect_valid &&
                   ((occupancy < (CW+1)'(DEPTH)) || ((occupancy == (CW+1)'(DEPTH)) && pop));

    // 65-bit compare so a PC near the top of the address space cannot wrap into range.
    always_comb begin
        issue_slot_valid = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            issue_slot_valid[i] = !fpc_misaligned &&
                                  (({1'b0, fpc} + 65'(4*i + 3)) < 65'(MEM_BYTES));
        end
    end

    always_ff @(posedge clk) begin
        if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
        if (issue) begin
            for (int k = 0; k < NB; k++) rd_bytes[k] <= mem[AW'(fpc + 64'(k))];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fpc           <= RESET_PC;
            s1_valid      <= 1'b0;
            s1_pc         <= '0;
            s1_slot_valid <= '0;
            s1_misalign   <= 1'b0;
            halt          <= 1'b0;
        end else if (bus.redirect_valid) begin
            fpc      <= bus.redirect_pc;
            s1_valid <= 1'b0;
            halt     <= 1'b0;
        end else begin
            s1_valid <= issue;
            if (issue) begin
                s1_pc         <= fpc;
                s1_slot_valid <= issue_slot_valid;
                s1_misalign   <= fpc_misaligned;
                fpc           <= fpc + 64'(NB);
                if (fpc_misaligned) halt <= 1'b1;
            end
        end
    end

    always_comb begin
        s1_bundle                          = '0;
        s1_bundle.pc                       = s1_pc;
        s1_bundle.misalign                 = s1_misalign;
        s1_bundle.slot_valid[ISSUE_W-1:0]  = s1_slot_valid;
        for (int i = 0; i < ISSUE_W; i++) begin
            s1_bundle.instr[i*ILEN +: ILEN] = s1_slot_valid[i]
                ? {rd_bytes[4*i+3], rd_bytes[4*i+2], rd_bytes[4*i+1], rd_bytes[4*i]}
                : NOP_INSTR;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (bus.redirect_valid),
        .push      (s1_valid),
        .push_data (s1_bundle),
        .pop       (pop),
        .head      (head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign bus.out_valid      = !q_empty;
    assign bus.out_pc         = head.pc;
    assign bus.out_instr      = head.instr[ISSUE_W*ILEN-1:0];
    assign bus.out_slot_valid = head.slot_valid[ISSUE_W-1:0];
    assign bus.out_misalign   = head.misalign;
    assign unused_full        = q_full;

    if (ISSUE_W < MAX_ISSUE_W) begin : g_unused_hi
        logic unused_hi;
        assign unused_hi = ^{head.instr[MAX_ISSUE_W*ILEN-1:ISSUE_W*ILEN],
                             head.slot_valid[MAX_ISSUE_W-1:ISSUE_W]};
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue (ISSUE_W=2, DEPTH=4, MEM_BYTES=65536).
module tb_instr_fetch_queue;
    import fetch_pkg::*;

    localparam int ISSUE_W   = 2;
    localparam int DEPTH     = 4;
    localparam int MEM_BYTES = 65536;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    instr_fetch_queue_if #(.ISSUE_W(ISSUE_W), .MEM_BYTES(MEM_BYTES)) bus ();

    instr_fetch_queue #(
        .ISSUE_W   (ISSUE_W),
        .DEPTH     (DEPTH),
        .MEM_BYTES (MEM_BYTES),
        .RESET_PC  (64'h0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [15:0] addr, input logic [31:0] data);
        for (int b = 0; b < 4; b++) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = addr + 16'(b);
            bus.wr_data = data[8*b +: 8];
            tick();
        end
        bus.wr_en = 1'b0;
    endtask

    task automatic redirect(input logic [63:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        tick();
        bus.redirect_valid = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 128'(bus.out_valid), 128'(1'b0));
        check({tag, "_pc"},    128'(bus.out_pc),    128'(64'h0));
        check({tag, "_instr"}, 128'(bus.out_instr), 128'(64'h0));
        check({tag, "_slot"},  128'(bus.out_slot_valid), 128'(2'b00));
        check({tag, "_mis"},   128'(bus.out_misalign), 128'(1'b0));
    endtask

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 64'h0;
        bus.out_ready      = 1'b0;
        bus.wr_en          = 1'b0;
        bus.wr_addr        = '0;
        bus.wr_data        = 8'h00;

        // Reset state.
        rst_n = 1'b0;
        tick(2);
        check_zero("reset");
        rst_n = 1'b1;

        write_word(16'h0004, 32'h015A04B3);
        write_word(16'h0008, 32'h00148493);
        write_word(16'hFFF8, 32'h00000093);

        // Redirect latency and first bundle contents.
        bus.out_ready = 1'b1;
        redirect(64'h4);
        check("t1_r1_valid", 128'(bus.out_valid), 128'(1'b0));
        tick();
        check("t1_r2_valid", 128'(bus.out_valid), 128'(1'b0));
        tick();
        check("t1_valid", 128'(bus.out_valid), 128'(1'b1));
        check("t1_pc",    128'(bus.out_pc),    128'(64'h4));
        check("t1_instr", 128'(bus.out_instr), 128'(64'h00148493_015A04B3));
        check("t1_slot",  128'(bus.out_slot_valid), 128'(2'b11));
        check("t1_mis",   128'(bus.out_misalign), 128'(1'b0));
        tick();
        check("t1_next_pc", 128'(bus.out_pc), 128'(64'hC));

        // Backpressure: queue fills, head holds, then drains without gaps.
        rst_n         = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick(10);
        check("t2_hold_valid", 128'(bus.out_valid), 128'(1'b1));
        check("t2_hold_pc",    128'(bus.out_pc),    128'(64'h0));
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t2_drain%0d_valid", i), 128'(bus.out_valid), 128'(1'b1));
            check($sformatf("t2_drain%0d_pc", i),    128'(bus.out_pc),    128'(64'(8*i)));
            tick();
        end

        // End of the instruction store.
        redirect(64'hFFF8);
        tick(2);
        check("t3a_pc",    128'(bus.out_pc), 128'(64'hFFF8));
        check("t3a_slot",  128'(bus.out_slot_valid), 128'(2'b11));
        check("t3a_slot0", 128'(bus.out_instr[31:0]), 128'(32'h00000093));
        tick();
        check("t3b_pc",    128'(bus.out_pc), 128'(64'h10000));
        check("t3b_slot",  128'(bus.out_slot_valid), 128'(2'b00));
        check("t3b_instr", 128'(bus.out_instr), 128'({NOP_INSTR, NOP_INSTR}));
        redirect(64'hFFFC);
        tick(2);
        check("t3c_pc",    128'(bus.out_pc), 128'(64'hFFFC));
        check("t3c_slot",  128'(bus.out_slot_valid), 128'(2'b01));
        check("t3c_slot1", 128'(bus.out_instr[63:32]), 128'(NOP_INSTR));

        // Misaligned PC: one flagged bundle, then fetch halts.
        redirect(64'h6);
        tick(2);
        check("t4_valid", 128'(bus.out_valid), 128'(1'b1));
        check("t4_pc",    128'(bus.out_pc), 128'(64'h6));
        check("t4_mis",   128'(bus.out_misalign), 128'(1'b1));
        check("t4_slot",  128'(bus.out_slot_valid), 128'(2'b00));
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t4_halt%0d_valid", i), 128'(bus.out_valid), 128'(1'b0));
        end
        redirect(64'h8);
        tick(2);
        check("t4_resume_pc",  128'(bus.out_pc), 128'(64'h8));
        check("t4_resume_mis", 128'(bus.out_misalign), 128'(1'b0));

        // Redirect coinciding with a head handshake on a full queue.
        bus.out_ready = 1'b0;
        tick(8);
        check("t5_full_valid", 128'(bus.out_valid), 128'(1'b1));
        bus.out_ready = 1'b1;
        redirect(64'h40);
        check("t5_r1_valid", 128'(bus.out_valid), 128'(1'b0));
        tick();
        check("t5_r2_valid", 128'(bus.out_valid), 128'(1'b0));
        tick();
        check("t5_pc",      128'(bus.out_pc), 128'(64'h40));
        tick();
        check("t5_next_pc", 128'(bus.out_pc), 128'(64'h48));

        // Reset wins over a simultaneous redirect.
        rst_n              = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h100;
        tick();
        bus.redirect_valid = 1'b0;
        check_zero("t6");
        rst_n = 1'b1;
        tick();
        check("t6_r2_valid", 128'(bus.out_valid), 128'(1'b0));
        tick();
        check("t6_valid", 128'(bus.out_valid), 128'(1'b1));
        check("t6_pc",    128'(bus.out_pc), 128'(64'h0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
